// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the memory-access stage: bus payloads,
// opcode / funct3 constants and the exception cause encoding.
package mem_access_unit_pkg;

   // Bus payload widths; data-carrying fields are sized for the widest (64-bit) datapath
   localparam int unsigned XLEN   = 64;
   localparam int unsigned INSN_W = 32;
   localparam int unsigned OPC_W  = 7;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned RD_W   = 5;

   // Major opcodes
   localparam logic [OPC_W-1:0] LOAD  = 7'b0000011;
   localparam logic [OPC_W-1:0] STORE = 7'b0100011;
   localparam logic [OPC_W-1:0] ALU_R = 7'b0110011;
   localparam logic [OPC_W-1:0] ALU_I = 7'b0010011;

   // Load funct3
   localparam logic [F3_W-1:0] LB  = 3'b000;
   localparam logic [F3_W-1:0] LH  = 3'b001;
   localparam logic [F3_W-1:0] LW  = 3'b010;
   localparam logic [F3_W-1:0] LD  = 3'b011;
   localparam logic [F3_W-1:0] LBU = 3'b100;
   localparam logic [F3_W-1:0] LHU = 3'b101;
   localparam logic [F3_W-1:0] LWU = 3'b110;

   // Store funct3
   localparam logic [F3_W-1:0] SB = 3'b000;
   localparam logic [F3_W-1:0] SH = 3'b001;
   localparam logic [F3_W-1:0] SW = 3'b010;
   localparam logic [F3_W-1:0] SD = 3'b011;

   typedef enum logic [1:0] {
      EXC_NONE       = 2'd0,
      EXC_MISALIGNED = 2'd1,
      EXC_ILLEGAL    = 2'd2,
      EXC_BUS_ERROR  = 2'd3
   } mem_exc_cause_e;

   typedef struct packed {
      logic [INSN_W-1:0] instruction;
      logic [OPC_W-1:0]  opcode;
      logic [F3_W-1:0]   funct3;
      logic [RD_W-1:0]   rd;
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   store_data;
   } ex_mem_bus_t;

   typedef struct packed {
      logic [INSN_W-1:0] instruction;
      logic [OPC_W-1:0]  opcode;
      logic [RD_W-1:0]   rd;
      logic [XLEN-1:0]   wb_value;
   } mem_wb_bus_t;

   // True for opcodes that access data memory
   function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
      return (opc == LOAD) || (opc == STORE);
   endfunction

endpackage

// File: rtl/mem_access_unit_lsu_lane_align.sv
// Combinational lane alignment for the memory-access stage.
//   addr_lo, funct3, is_store : access descriptor (low address bits, size/sign, direction)
//   store_data -> be_c, wdata_c : store byte enables and lane-replicated write data
//   rdata -> load_value_c       : response shifted down by the offset and extended
//   misaligned_c, illegal_c     : access legality (illegal takes precedence)
module lsu_lane_align
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [2:0]          addr_lo,
   input  logic [F3_W-1:0]     funct3,
   input  logic                is_store,
   input  logic [DATA_W-1:0]   store_data,
   input  logic [DATA_W-1:0]   rdata,
   output logic [DATA_W/8-1:0] be_c,
   output logic [DATA_W-1:0]   wdata_c,
   output logic [DATA_W-1:0]   load_value_c,
   output logic                misaligned_c,
   output logic                illegal_c
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam bit          HAS_D = (DATA_W == 64);

   logic [OFF_W-1:0]  off;
   logic [DATA_W-1:0] sh;
   logic signed [7:0]  sb;
   logic signed [15:0] shw;
   logic signed [31:0] sw;
   logic               mis_raw;

   assign off = addr_lo[OFF_W-1:0];
   assign sh  = rdata >> {off, 3'b000};
   assign sb  = sh[7:0];
   assign shw = sh[15:0];
   assign sw  = sh[31:0];

   // Legality and natural-alignment check
   always_comb begin
      illegal_c = 1'b0;
      if (is_store) begin
         illegal_c = funct3[2] | ((funct3[1:0] == 2'b11) & !HAS_D);
      end else begin
         case (funct3)
            LB, LH, LW, LBU, LHU: illegal_c = 1'b0;
            LD, LWU:              illegal_c = !HAS_D;
            default:              illegal_c = 1'b1;
         endcase
      end

      case (funct3[1:0])
         2'b00:   mis_raw = 1'b0;
         2'b01:   mis_raw = addr_lo[0];
         2'b10:   mis_raw = |addr_lo[1:0];
         default: mis_raw = |addr_lo;
      endcase
      misaligned_c = mis_raw & !illegal_c;
   end

   // Store lane placement: data replicated across all lanes, enables select the target bytes
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be_c    = BE_W'(1) << off;
            wdata_c = {BE_W{store_data[7:0]}};
         end
         2'b01: begin
            be_c    = BE_W'(2'b11) << off;
            wdata_c = {(DATA_W/16){store_data[15:0]}};
         end
         2'b10: begin
            be_c    = BE_W'(4'hF) << off;
            wdata_c = {(DATA_W/32){store_data[31:0]}};
         end
         default: begin
            be_c    = '1;
            wdata_c = store_data;
         end
      endcase
   end

   // Load extraction with sign/zero extension
   always_comb begin
      case (funct3)
         LB:  load_value_c = DATA_W'(sb);
         LH:  load_value_c = DATA_W'(shw);
         LW: begin
            if (HAS_D) load_value_c = DATA_W'(sw);
            else       load_value_c = DATA_W'(sh[31:0]);
         end
         LBU: load_value_c = DATA_W'(sh[7:0]);
         LHU: load_value_c = DATA_W'(sh[15:0]);
         LWU: load_value_c = DATA_W'(sh[31:0]);
         default: load_value_c = sh;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage between EX/MEM and MEM/WB.
//   clock, reset (async, active-low)
//   in_valid / ex_mem_bus_in / in_ready        : upstream instruction handshake
//   dmem_req_* / dmem_req_ready                 : data-memory request (valid/ready)
//   dmem_rsp_valid / dmem_rsp_rdata             : data-memory response (loads and stores)
//   out_valid / mem_wb_bus_out                  : registered writeback bus, one-cycle pulse
//   exc_valid / exc_cause / exc_addr            : exception report, qualified by out_valid
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   input  ex_mem_bus_t         ex_mem_bus_in,
   output logic                in_ready,
   output logic                dmem_req_valid,
   output logic                dmem_req_we,
   output logic [ADDR_W-1:0]   dmem_req_addr,
   output logic [DATA_W-1:0]   dmem_req_wdata,
   output logic [DATA_W/8-1:0] dmem_req_be,
   input  logic                dmem_req_ready,
   input  logic                dmem_rsp_valid,
   input  logic [DATA_W-1:0]   dmem_rsp_rdata,
   output logic                out_valid,
   output mem_wb_bus_t         mem_wb_bus_out,
   output logic                exc_valid,
   output logic [1:0]          exc_cause,
   output logic [ADDR_W-1:0]   exc_addr
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]       state, next_state;
   ex_mem_bus_t      hold, hold_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             in_ready_d;
   logic             req_valid_d, req_we_d;
   logic [ADDR_W-1:0] req_addr_d;
   logic [DATA_W-1:0] req_wdata_d;
   logic [BE_W-1:0]   req_be_d;
   logic             out_valid_d, exc_valid_d;
   mem_wb_bus_t      wb_d;
   mem_exc_cause_e   exc_cause_q, exc_cause_d;
   logic [ADDR_W-1:0] exc_addr_d;

   // Lane aligner sees the incoming bus while idle (store placement, legality)
   // and the held bus afterwards (load extraction).
   ex_mem_bus_t       sel;
   logic [ADDR_W-1:0] in_addr, hold_addr;
   logic [BE_W-1:0]   be_c;
   logic [DATA_W-1:0] wdata_c, load_value_c;
   logic              misaligned_c, illegal_c;
   logic              unused_bits;

   assign sel       = (state == ST_IDLE) ? ex_mem_bus_in : hold;
   assign in_addr   = ADDR_W'(ex_mem_bus_in.alu_result);
   assign hold_addr = ADDR_W'(hold.alu_result);
   assign exc_cause = exc_cause_q;
   assign unused_bits = ^{sel.alu_result, sel.store_data, hold.alu_result,
                          ex_mem_bus_in.alu_result, ex_mem_bus_in.store_data};

   lsu_lane_align #(
      .DATA_W (DATA_W)
   ) u_lane_align (
      .addr_lo      (sel.alu_result[2:0]),
      .funct3       (sel.funct3),
      .is_store     (sel.opcode == STORE),
      .store_data   (DATA_W'(sel.store_data)),
      .rdata        (dmem_rsp_rdata),
      .be_c         (be_c),
      .wdata_c      (wdata_c),
      .load_value_c (load_value_c),
      .misaligned_c (misaligned_c),
      .illegal_c    (illegal_c)
   );

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         hold           <= '0;
         cnt            <= '0;
         in_ready       <= 1'b1;
         dmem_req_valid <= 1'b0;
         dmem_req_we    <= 1'b0;
         dmem_req_addr  <= '0;
         dmem_req_wdata <= '0;
         dmem_req_be    <= '0;
         out_valid      <= 1'b0;
         mem_wb_bus_out <= '0;
         exc_valid      <= 1'b0;
         exc_cause_q    <= EXC_NONE;
         exc_addr       <= '0;
      end else begin
         state          <= next_state;
         hold           <= hold_d;
         cnt            <= cnt_d;
         in_ready       <= in_ready_d;
         dmem_req_valid <= req_valid_d;
         dmem_req_we    <= req_we_d;
         dmem_req_addr  <= req_addr_d;
         dmem_req_wdata <= req_wdata_d;
         dmem_req_be    <= req_be_d;
         out_valid      <= out_valid_d;
         mem_wb_bus_out <= wb_d;
         exc_valid      <= exc_valid_d;
         exc_cause_q    <= exc_cause_d;
         exc_addr       <= exc_addr_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      next_state  = state;
      hold_d      = hold;
      cnt_d       = cnt;
      req_valid_d = dmem_req_valid;
      req_we_d    = dmem_req_we;
      req_addr_d  = dmem_req_addr;
      req_wdata_d = dmem_req_wdata;
      req_be_d    = dmem_req_be;
      out_valid_d = 1'b0;
      exc_valid_d = 1'b0;
      wb_d        = mem_wb_bus_out;
      exc_cause_d = exc_cause_q;
      exc_addr_d  = exc_addr;

      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               wb_d.instruction = ex_mem_bus_in.instruction;
               wb_d.opcode      = ex_mem_bus_in.opcode;
               wb_d.rd          = ex_mem_bus_in.rd;
               if (!is_mem_op(ex_mem_bus_in.opcode)) begin
                  out_valid_d = 1'b1;
                  exc_cause_d = EXC_NONE;
                  exc_addr_d  = '0;
                  if ((ex_mem_bus_in.opcode == ALU_R) || (ex_mem_bus_in.opcode == ALU_I))
                     wb_d.wb_value = XLEN'(ex_mem_bus_in.alu_result[DATA_W-1:0]);
                  else
                     wb_d.wb_value = '0;
               end else begin
                  hold_d = ex_mem_bus_in;
                  if (illegal_c || misaligned_c) begin
                     // Rejected without touching memory
                     out_valid_d   = 1'b1;
                     exc_valid_d   = 1'b1;
                     exc_cause_d   = illegal_c ? EXC_ILLEGAL : EXC_MISALIGNED;
                     exc_addr_d    = in_addr;
                     wb_d.wb_value = '0;
                  end else begin
                     next_state  = ST_REQ;
                     req_valid_d = 1'b1;
                     req_we_d    = (ex_mem_bus_in.opcode == STORE);
                     req_addr_d  = {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                     if (ex_mem_bus_in.opcode == STORE) begin
                        req_wdata_d = wdata_c;
                        req_be_d    = be_c;
                     end else begin
                        req_wdata_d = '0;
                        req_be_d    = '1;
                     end
                  end
               end
            end
         end

         ST_REQ: begin
            if (dmem_req_ready) begin
               req_valid_d = 1'b0;
               cnt_d       = '0;
               next_state  = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // A response in the timeout cycle still completes normally
            if (dmem_rsp_valid) begin
               out_valid_d = 1'b1;
               exc_cause_d = EXC_NONE;
               exc_addr_d  = '0;
               if (hold.opcode == STORE) wb_d.wb_value = '0;
               else                      wb_d.wb_value = XLEN'(load_value_c);
               next_state  = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               out_valid_d   = 1'b1;
               exc_valid_d   = 1'b1;
               exc_cause_d   = EXC_BUS_ERROR;
               exc_addr_d    = hold_addr;
               wb_d.wb_value = '0;
               next_state    = ST_IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end

         default: next_state = ST_IDLE;
      endcase

      in_ready_d = (next_state == ST_IDLE);
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (DATA_W=32, TIMEOUT_CYCLES=4).
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clock;
   logic        reset;
   logic        in_valid;
   ex_mem_bus_t bus_in;
   logic        in_ready;
   logic        dmem_req_valid, dmem_req_we;
   logic [31:0] dmem_req_addr, dmem_req_wdata;
   logic [3:0]  dmem_req_be;
   logic        dmem_req_ready, dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        out_valid;
   mem_wb_bus_t wb_out;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit #(
      .DATA_W         (32),
      .ADDR_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .ex_mem_bus_in  (bus_in),
      .in_ready       (in_ready),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_we    (dmem_req_we),
      .dmem_req_addr  (dmem_req_addr),
      .dmem_req_wdata (dmem_req_wdata),
      .dmem_req_be    (dmem_req_be),
      .dmem_req_ready (dmem_req_ready),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rsp_rdata (dmem_rsp_rdata),
      .out_valid      (out_valid),
      .mem_wb_bus_out (wb_out),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_addr       (exc_addr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one instruction and hold it for exactly one accepting edge
   task automatic accept(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata);
      int k = 0;
      while (!in_ready && k < 20) begin
         tick();
         k++;
      end
      check("in_ready_before_accept", 64'(in_ready), 64'd1);
      bus_in.instruction = 32'hC0DE_0000 | 32'(opc);
      bus_in.opcode      = opc;
      bus_in.funct3      = f3;
      bus_in.rd          = 5'd9;
      bus_in.alu_result  = 64'(addr);
      bus_in.store_data  = 64'(sdata);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [63:0] exp);
      accept(LOAD, f3, addr, 32'h0);
      check({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
      check({tag, "_req_we"},    64'(dmem_req_we), 64'd0);
      check({tag, "_req_addr"},  64'(dmem_req_addr), 64'(addr & 32'hFFFF_FFFC));
      check({tag, "_req_be"},    64'(dmem_req_be), 64'hF);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      check({tag, "_in_ready_wait"}, 64'(in_ready), 64'd0);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = rdata;
      tick();
      dmem_rsp_valid = 1'b0;
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_wb"},        wb_out.wb_value, exp);
      check({tag, "_exc_valid"}, 64'(exc_valid), 64'd0);
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input int stall);
      accept(STORE, f3, addr, sdata);
      for (int i = 0; i <= stall; i++) begin
         check({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
         check({tag, "_req_we"},    64'(dmem_req_we), 64'd1);
         check({tag, "_req_addr"},  64'(dmem_req_addr), 64'(addr & 32'hFFFF_FFFC));
         check({tag, "_req_be"},    64'(dmem_req_be), 64'(exp_be));
         check({tag, "_req_wdata"}, 64'(dmem_req_wdata), 64'(exp_wdata));
         if (i < stall) tick();
      end
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b1;
      tick();
      dmem_rsp_valid = 1'b0;
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_wb"},        wb_out.wb_value, 64'd0);
   endtask

   initial begin
      reset          = 1'b0;
      in_valid       = 1'b0;
      bus_in         = '0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = '0;

      // Reset state
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      check("rst_exc_valid", 64'(exc_valid), 64'd0);
      check("rst_req_be",    64'(dmem_req_be), 64'd0);
      check("rst_wb",        wb_out.wb_value, 64'd0);
      reset = 1'b1;
      tick();

      // ALU ops back to back, then a non-ALU pass-through
      accept(ALU_R, 3'b000, 32'h1234, 32'h0);
      check("alu_r_out_valid", 64'(out_valid), 64'd1);
      check("alu_r_wb",        wb_out.wb_value, 64'h1234);
      check("alu_r_in_ready",  64'(in_ready), 64'd1);
      check("alu_r_rd",        64'(wb_out.rd), 64'd9);
      accept(ALU_I, 3'b000, 32'h5678, 32'h0);
      check("alu_i_wb",        wb_out.wb_value, 64'h5678);
      accept(7'b0110111, 3'b000, 32'h999, 32'h0);
      check("other_out_valid", 64'(out_valid), 64'd1);
      check("other_wb",        wb_out.wb_value, 64'd0);
      tick();
      check("alu_pulse_end",   64'(out_valid), 64'd0);

      // Loads with offsets and extension
      do_load("lbu", LBU, 32'h103, 32'h80FF_0000, 64'h0000_0080);
      do_load("lb",  LB,  32'h103, 32'h80FF_0000, 64'hFFFF_FF80);
      do_load("lhu", LHU, 32'h102, 32'h80FF_0000, 64'h0000_80FF);
      do_load("lh",  LH,  32'h102, 32'h80FF_0000, 64'hFFFF_80FF);
      do_load("lb0", LB,  32'h100, 32'h80FF_007F, 64'h0000_007F);
      do_load("lw",  LW,  32'h104, 32'hDEAD_BEEF, 64'hDEAD_BEEF);

      // Stores, one with a stalled request
      do_store("sb", SB, 32'h101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 3);
      do_store("sh", SH, 32'h102, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF, 0);
      do_store("sw", SW, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0);

      // Misaligned word load
      accept(LOAD, LW, 32'h102, 32'h0);
      check("mis_req_valid", 64'(dmem_req_valid), 64'd0);
      check("mis_out_valid", 64'(out_valid), 64'd1);
      check("mis_exc_valid", 64'(exc_valid), 64'd1);
      check("mis_exc_cause", 64'(exc_cause), 64'd1);
      check("mis_exc_addr",  64'(exc_addr), 64'h102);
      check("mis_wb",        wb_out.wb_value, 64'd0);
      check("mis_in_ready",  64'(in_ready), 64'd1);

      // LD is illegal on a 32-bit datapath
      accept(LOAD, LD, 32'h100, 32'h0);
      check("ill_req_valid", 64'(dmem_req_valid), 64'd0);
      check("ill_exc_valid", 64'(exc_valid), 64'd1);
      check("ill_exc_cause", 64'(exc_cause), 64'd2);
      check("ill_exc_addr",  64'(exc_addr), 64'h100);

      // Timeout after four WAIT cycles, then a stale response
      accept(LOAD, LW, 32'h200, 32'h0);
      check("to_req_valid", 64'(dmem_req_valid), 64'd1);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_wait_out_valid", 64'(out_valid), 64'd0);
         check("to_wait_in_ready",  64'(in_ready), 64'd0);
         tick();
      end
      check("to_out_valid", 64'(out_valid), 64'd1);
      check("to_exc_valid", 64'(exc_valid), 64'd1);
      check("to_exc_cause", 64'(exc_cause), 64'd3);
      check("to_exc_addr",  64'(exc_addr), 64'h200);
      check("to_wb",        wb_out.wb_value, 64'd0);
      check("to_in_ready",  64'(in_ready), 64'd1);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'h5555_5555;
      tick();
      dmem_rsp_valid = 1'b0;
      check("stale_out_valid", 64'(out_valid), 64'd0);
      check("stale_req_valid", 64'(dmem_req_valid), 64'd0);

      // Response in the timeout cycle wins
      accept(LOAD, LW, 32'h204, 32'h0);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      tick();
      tick();
      tick();
      check("race_pending", 64'(out_valid), 64'd0);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'h1111_2222;
      tick();
      dmem_rsp_valid = 1'b0;
      check("race_out_valid", 64'(out_valid), 64'd1);
      check("race_exc_valid", 64'(exc_valid), 64'd0);
      check("race_wb",        wb_out.wb_value, 64'h1111_2222);

      // Reset while waiting abandons the access
      accept(LOAD, LW, 32'h300, 32'h0);
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      reset = 1'b0;
      #1;
      check("wrst_out_valid", 64'(out_valid), 64'd0);
      check("wrst_req_valid", 64'(dmem_req_valid), 64'd0);
      check("wrst_exc_valid", 64'(exc_valid), 64'd0);
      check("wrst_req_be",    64'(dmem_req_be), 64'd0);
      check("wrst_req_addr",  64'(dmem_req_addr), 64'd0);
      check("wrst_exc_cause", 64'(exc_cause), 64'd0);
      check("wrst_wb",        wb_out.wb_value, 64'd0);
      tick();
      tick();
      reset = 1'b1;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'h7777_7777;
      tick();
      dmem_rsp_valid = 1'b0;
      check("late_rsp_out_valid", 64'(out_valid), 64'd0);
      check("late_rsp_in_ready",  64'(in_ready), 64'd1);
      accept(ALU_R, 3'b000, 32'h42, 32'h0);
      check("post_rst_alu_valid", 64'(out_valid), 64'd1);
      check("post_rst_alu_wb",    wb_out.wb_value, 64'h42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
